lm1_approx_mult: RTL and testbench

- Registered 4x4-bit unsigned approximate multiplier. The FPGA-oriented variant trades exactness of selected 2x2 partial products for fewer LUTs.
- Operands split into 2-bit halves. Four 2x2 sub-products are each exact or approximate, then shifted and summed into an 8-bit product.
- Used as the leaf multiplier in the approximate-arithmetic datapath and characterised exhaustively by error metrics (occurrences, distance, max error, relative error).

---
 rtl/lm1_approx_mult.sv | 60 ++++++
 tb/tb_lm1_approx_mult.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lm1_approx_mult.sv
// Registered 4x4 unsigned approximate multiplier built from four 2x2 cells (exact or 3*3->7 approximate).
// Latency: 1 cycle from in_valid to out_valid. Backpressure: none, accepts operands every cycle.
// Build macro LM1_EXACT_EN forces every cell exact (golden reference mode) regardless of APPROX_MASK.
module lm1_approx_mult #(
    parameter logic [3:0] APPROX_MASK = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    output logic [7:0] prod
);

`ifdef LM1_EXACT_EN
    localparam logic [3:0] EFF_MASK = 4'b0000;
`else
    localparam logic [3:0] EFF_MASK = APPROX_MASK;
`endif

    // The approximate cell only differs at 3*3, which it reports as 7 so the result fits in 3 bits.
    function automatic logic [3:0] cell2(input logic [1:0] x, input logic [1:0] y, input logic approx);
        logic [3:0] p;
        p = {2'b00, x} * {2'b00, y};
        if (approx && (x == 2'd3) && (y == 2'd3)) begin
            p = 4'd7;
        end
        return p;
    endfunction

    logic [3:0] ll, lh, hl, hh;
    logic [7:0] prod_next;
    logic [7:0] prod_d, prod_q;
    logic       out_valid_d, out_valid_q;

    always_comb begin
        ll = cell2(a[1:0], b[1:0], EFF_MASK[0]);
        lh = cell2(a[1:0], b[3:2], EFF_MASK[1]);
        hl = cell2(a[3:2], b[1:0], EFF_MASK[2]);
        hh = cell2(a[3:2], b[3:2], EFF_MASK[3]);
        prod_next = {hh, 4'b0000} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {4'b0000, ll};
        prod_d      = in_valid ? prod_next : prod_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign prod      = prod_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lm1_approx_mult.sv
// Bench for lm1_approx_mult: default-mask and all-approximate instances against an arithmetic reference.
module tb_lm1_approx_mult;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic       out_valid_d0, out_valid_af;
    logic [7:0] prod_d0, prod_af;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lm1_approx_mult #(.APPROX_MASK(4'b0001)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid_d0), .prod(prod_d0)
    );

    lm1_approx_mult #(.APPROX_MASK(4'b1111)) dut_af (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid_af), .prod(prod_af)
    );

`ifdef LM1_EXACT_EN
    localparam int EXP_3X3     = 9;
    localparam int EXP_15X15   = 225;
    localparam int EXP_AF_15   = 225;
    localparam int EXP_AF_7X11 = 77;
    localparam int EXP_ERRS    = 0;
    localparam int EXP_MAXERR  = 0;
`else
    localparam int EXP_3X3     = 7;
    localparam int EXP_15X15   = 223;
    localparam int EXP_AF_15   = 175;
    localparam int EXP_AF_7X11 = 75;
    localparam int EXP_ERRS    = 16;
    localparam int EXP_MAXERR  = 2;
`endif

    // Reference: exact product, minus 2 (the 9->7 shortfall) scaled by the weight of every approximated block hitting 3*3.
    function automatic int ref_prod(input logic [3:0] mask, input int x, input int y);
        int p;
        int xl, xh, yl, yh;
        logic [3:0] m;
        m = mask;
`ifdef LM1_EXACT_EN
        m = 4'b0000;
`endif
        xl = x % 4; xh = x / 4; yl = y % 4; yh = y / 4;
        p = x * y;
        if (m[0] && xl == 3 && yl == 3) p = p - 2;
        if (m[1] && xl == 3 && yh == 3) p = p - 2 * 4;
        if (m[2] && xh == 3 && yl == 3) p = p - 2 * 4;
        if (m[3] && xh == 3 && yh == 3) p = p - 2 * 16;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then look 1 time unit after the capturing rising edge.
    task automatic step(input logic r, input logic v, input int x, input int y);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = x[3:0];
        b        = y[3:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errs, maxerr, above, ed, x, y;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        // Reset with valid operands present: reset wins.
        step(1'b1, 1'b1, 15, 15);
        chk("rst1_prod", 32'(prod_d0), 0);
        chk("rst1_vld", 32'(out_valid_d0), 0);
        step(1'b1, 1'b1, 15, 15);
        chk("rst2_prod", 32'(prod_d0), 0);
        chk("rst2_vld", 32'(out_valid_d0), 0);
        step(1'b0, 1'b1, 15, 15);
        chk("first_15x15", 32'(prod_d0), EXP_15X15);
        chk("first_vld", 32'(out_valid_d0), 1);
        chk("af_15x15", 32'(prod_af), EXP_AF_15);

        step(1'b0, 1'b1, 3, 3);
        chk("d_3x3", 32'(prod_d0), EXP_3X3);
        chk("d_3x3_vld", 32'(out_valid_d0), 1);
        // Operands change while idle: the product must hold.
        step(1'b0, 1'b0, 15, 15);
        chk("hold_prod", 32'(prod_d0), EXP_3X3);
        chk("hold_vld", 32'(out_valid_d0), 0);

        step(1'b0, 1'b1, 6, 5);    chk("d_6x5", 32'(prod_d0), 30);
        step(1'b0, 1'b1, 12, 12);  chk("d_12x12", 32'(prod_d0), 144);
        step(1'b0, 1'b1, 1, 15);   chk("d_1x15", 32'(prod_d0), 15);
        step(1'b0, 1'b1, 0, 9);    chk("d_0x9", 32'(prod_d0), 0);
        chk("af_0x9", 32'(prod_af), 0);
        step(1'b0, 1'b1, 9, 0);    chk("af_9x0", 32'(prod_af), 0);
        step(1'b0, 1'b1, 7, 11);   chk("af_7x11", 32'(prod_af), EXP_AF_7X11);

        // Mid-stream reset discards the in-flight operands.
        step(1'b1, 1'b1, 13, 14);
        chk("mid_rst_prod", 32'(prod_d0), 0);
        chk("mid_rst_vld", 32'(out_valid_d0), 0);
        step(1'b0, 1'b0, 13, 14);
        chk("post_rst_idle_vld", 32'(out_valid_d0), 0);
        chk("post_rst_idle_prod", 32'(prod_d0), 0);
        step(1'b0, 1'b1, 13, 14);
        chk("post_rst_prod", 32'(prod_d0), ref_prod(4'b0001, 13, 14));
        chk("post_rst_vld", 32'(out_valid_d0), 1);

        // Back-to-back exhaustive sweep, collecting error metrics against the exact product.
        errs = 0; maxerr = 0; above = 0;
        for (int i = 1; i < 16; i++) begin
            for (int j = 1; j < 16; j++) begin
                step(1'b0, 1'b1, i, j);
                chk($sformatf("sweep_%0dx%0d", i, j), 32'(prod_d0), ref_prod(4'b0001, i, j));
                chk($sformatf("sweep_af_%0dx%0d", i, j), 32'(prod_af), ref_prod(4'b1111, i, j));
                if (int'(prod_d0) > i * j) above++;
                ed = i * j - int'(prod_d0);
                if (ed != 0) errs++;
                if (ed > maxerr) maxerr = ed;
            end
        end
        chk("sweep_err_count", errs, EXP_ERRS);
        chk("sweep_max_err", maxerr, EXP_MAXERR);
        chk("sweep_above_exact", above, 0);

        // Random traffic with random idle gaps.
        for (int k = 0; k < 300; k++) begin
            logic v;
            int   last_d0, last_af;
            last_d0 = int'(prod_d0);
            last_af = int'(prod_af);
            v = ($urandom_range(0, 3) != 0);
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            step(1'b0, v, x, y);
            chk("rnd_vld", 32'(out_valid_d0), 32'(v));
            chk("rnd_d0", 32'(prod_d0), v ? ref_prod(4'b0001, x, y) : last_d0);
            chk("rnd_af", 32'(prod_af), v ? ref_prod(4'b1111, x, y) : last_af);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
